// File: rtl/spi_mcp4921_dac.sv
// SPI mode-0 transmitter for the MCP4921 12-bit DAC.
// Each accepted sample becomes one 16-bit write command to DAC A, shifted out MSB first.
// The frame is followed by a CS hold period and an LDAC strobe that latches the new code.
module spi_mcp4921_dac #(
    parameter int unsigned CLK_DIV = 4,
    parameter logic        BUF     = 1'b0,
    parameter logic        GA_N    = 1'b1,
    parameter logic        SHDN_N  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sample_valid,
    input  logic [11:0] sample,
    output logic        ready,
    output logic        overrun,
    output logic        dac_cs_n,
    output logic        dac_sck,
    output logic        dac_mosi,
    output logic        dac_ldac_n
);

    localparam int unsigned    CW      = $clog2(CLK_DIV) + 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD,
        LDAC
    } state_t;

    state_t          state_q;
    logic [14:0]     shiftReg_q;
    logic [3:0]      bitCnt_q;
    logic [CW-1:0]   halfCnt_q;
    logic            ready_q;
    logic            overrun_q;
    logic            csN_q;
    logic            sck_q;
    logic            mosi_q;
    logic            ldacN_q;
    logic [15:0]     frame_d;

    // Command word: DAC A select, configuration bits, then the 12-bit code.
    assign frame_d = {1'b0, BUF, GA_N, SHDN_N, sample};

    // Frame sequencer; every output comes straight from a register so nothing
    // combinational reaches the pins. Bit 15 goes out directly at acceptance,
    // the shift register carries the remaining 15 bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            shiftReg_q <= '0;
            bitCnt_q   <= '0;
            halfCnt_q  <= '0;
            ready_q    <= 1'b1;
            overrun_q  <= 1'b0;
            csN_q      <= 1'b1;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b0;
            ldacN_q    <= 1'b1;
        end else begin
            overrun_q <= sample_valid & ~ready_q;
            case (state_q)
                IDLE: begin
                    if (sample_valid) begin
                        shiftReg_q <= frame_d[14:0];
                        mosi_q     <= frame_d[15];
                        bitCnt_q   <= 4'd15;
                        halfCnt_q  <= '0;
                        sck_q      <= 1'b0;
                        csN_q      <= 1'b0;
                        ready_q    <= 1'b0;
                        state_q    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (halfCnt_q == CNT_MAX) begin
                        halfCnt_q <= '0;
                        if (!sck_q) begin
                            sck_q <= 1'b1;
                        end else begin
                            sck_q <= 1'b0;
                            if (bitCnt_q == 4'd0) begin
                                state_q <= HOLD;
                            end else begin
                                bitCnt_q   <= bitCnt_q - 4'd1;
                                mosi_q     <= shiftReg_q[14];
                                shiftReg_q <= {shiftReg_q[13:0], 1'b0};
                            end
                        end
                    end else begin
                        halfCnt_q <= halfCnt_q + 1'b1;
                    end
                end
                HOLD: begin
                    if (halfCnt_q == CNT_MAX) begin
                        halfCnt_q <= '0;
                        csN_q     <= 1'b1;
                        ldacN_q   <= 1'b0;
                        state_q   <= LDAC;
                    end else begin
                        halfCnt_q <= halfCnt_q + 1'b1;
                    end
                end
                LDAC: begin
                    if (halfCnt_q == CNT_MAX) begin
                        halfCnt_q <= '0;
                        ldacN_q   <= 1'b1;
                        ready_q   <= 1'b1;
                        mosi_q    <= 1'b0;
                        state_q   <= IDLE;
                    end else begin
                        halfCnt_q <= halfCnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready      = ready_q;
    assign overrun    = overrun_q;
    assign dac_cs_n   = csN_q;
    assign dac_sck    = sck_q;
    assign dac_mosi   = mosi_q;
    assign dac_ldac_n = ldacN_q;

endmodule

// File: tb/tb_spi_mcp4921_dac.sv
// Scoreboard bench for spi_mcp4921_dac: one instance with default settings
// (CLK_DIV=4) and one with CLK_DIV=1, BUF=1, GA_N=0.
module tb_spi_mcp4921_dac;

    typedef struct {
        int          ch;
        logic [15:0] frame;
        int          t0;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  valid = 2'b00;
    logic [11:0] samp0 = 12'h000;
    logic [11:0] samp1 = 12'h000;
    logic [1:0]  rdy, ov, csN, sck, mosi, ldacN;

    int   cyc = 0;
    int   testsRun = 0;
    int   testsFailed = 0;
    exp_t sb[$];

    int          ovCount[2]   = '{0, 0};
    int          ldacFalls[2] = '{0, 0};
    int          runLen[2]    = '{0, 0};
    int          ldacRun[2]   = '{0, 0};
    int          bitCount[2]  = '{0, 0};
    logic [15:0] word[2];
    logic [1:0]  prevCs = 2'b11, prevSck = 2'b00, prevLdac = 2'b11, prevR = 2'b11;

    spi_mcp4921_dac #(.CLK_DIV(4)) dut4 (
        .clk(clk), .reset(reset), .sample_valid(valid[0]), .sample(samp0),
        .ready(rdy[0]), .overrun(ov[0]), .dac_cs_n(csN[0]), .dac_sck(sck[0]),
        .dac_mosi(mosi[0]), .dac_ldac_n(ldacN[0])
    );

    spi_mcp4921_dac #(.CLK_DIV(1), .BUF(1'b1), .GA_N(1'b0)) dut1 (
        .clk(clk), .reset(reset), .sample_valid(valid[1]), .sample(samp1),
        .ready(rdy[1]), .overrun(ov[1]), .dac_cs_n(csN[1]), .dac_sck(sck[1]),
        .dac_mosi(mosi[1]), .dac_ldac_n(ldacN[1])
    );

    // 100 MHz-style free running clock; the period value itself is arbitrary.
    always #5 clk = ~clk;

    // Cycle index used to timestamp acceptances and frame events.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int divOf(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic failNow(input string name, input string detail);
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL %s: %s (cycle %0d)", name, detail, cyc);
    endtask

    // Offers one sample on channel k (called at a falling edge); pushes the
    // expected frame when the handshake completes. hold keeps valid asserted.
    task automatic applyStimulus(input int k, input logic [11:0] s, input logic [15:0] f,
                                 input bit hold, output int t0);
        t0 = -1;
        if (k == 0) samp0 = s; else samp1 = s;
        valid[k] = 1'b1;
        for (int n = 0; n < 400; n++) begin
            if (rdy[k]) begin
                t0 = cyc;
                sb.push_back(exp_t'{ch: k, frame: f, t0: cyc});
                @(negedge clk);
                if (!hold) valid[k] = 1'b0;
                return;
            end
            @(negedge clk);
        end
        valid[k] = 1'b0;
        failNow("accept timeout", "got no acceptance, expected one within 400 cycles");
    endtask

    task automatic waitDone(input int k);
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (sb.size() == 0 && rdy[k]) return;
        end
        failNow("frame timeout", "got frame still pending, expected completion within 400 cycles");
        sb.delete();
    endtask

    // Monitor: samples 3 time units after each rising edge, rebuilds each frame
    // from MOSI at SCK rising edges and checks timing against the scoreboard.
    always begin
        @(posedge clk);
        #3;
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                prevCs[k] = 1'b1; prevSck[k] = 1'b0; prevLdac[k] = 1'b1;
            end else begin
                checkOutput($sformatf("overrun ch%0d", k), ov[k], valid[k] & ~prevR[k]);
                if (ov[k]) ovCount[k]++;
                if (prevCs[k] && !csN[k]) begin
                    if (sb.size() == 0) begin
                        failNow("frame start", "got unexpected CS fall, expected none");
                    end else begin
                        checkOutput("frame channel", sb[0].ch, k);
                        checkOutput("cs fall cycle", cyc, sb[0].t0 + 1);
                    end
                    checkOutput("sck low at cs fall", sck[k], 1'b0);
                    runLen[k] = 1; bitCount[k] = 0; word[k] = 16'h0000;
                end else if (!csN[k]) begin
                    if (sck[k] != prevSck[k]) begin
                        checkOutput($sformatf("sck half ch%0d", k), runLen[k], divOf(k));
                        runLen[k] = 1;
                        if (sck[k]) begin
                            word[k] = {word[k][14:0], mosi[k]};
                            bitCount[k]++;
                        end
                    end else begin
                        runLen[k]++;
                    end
                end
                if (!prevCs[k] && csN[k]) begin
                    checkOutput("cs hold length", runLen[k], divOf(k));
                    checkOutput("sck edge count", bitCount[k], 16);
                    checkOutput("ldac low at cs rise", ldacN[k], 1'b0);
                    if (sb.size() == 0) failNow("frame word", "got frame with no expected entry");
                    else begin
                        checkOutput($sformatf("frame word ch%0d", k), word[k], sb[0].frame);
                        checkOutput("mosi holds bit0", mosi[k], sb[0].frame[0]);
                    end
                end
                if (prevLdac[k] && !ldacN[k]) begin
                    ldacFalls[k]++;
                    ldacRun[k] = 1;
                end else if (!ldacN[k]) begin
                    ldacRun[k]++;
                    checkOutput("cs high during ldac", csN[k], 1'b1);
                end
                if (!prevLdac[k] && ldacN[k]) begin
                    checkOutput("ldac width", ldacRun[k], divOf(k));
                    checkOutput("ready at ldac end", rdy[k], 1'b1);
                    checkOutput("mosi idle", mosi[k], 1'b0);
                    if (sb.size() > 0) begin
                        checkOutput($sformatf("ready latency ch%0d", k), cyc, sb[0].t0 + 1 + 34 * divOf(k));
                        void'(sb.pop_front());
                    end
                end
                prevCs[k] = csN[k]; prevSck[k] = sck[k]; prevLdac[k] = ldacN[k];
            end
            prevR[k] = rdy[k];
        end
    end

    // Safety net so the run always ends even if the directed sequence stalls.
    initial begin
        #200000;
        failNow("global timeout", "got no end of test, expected finish within 20000 cycles");
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    // Directed sequence with hand-computed frames.
    initial begin
        int t0, ta, tb, ovBase, ldBase, n;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checkOutput("reset ready", rdy[k], 1'b1);
            checkOutput("reset overrun", ov[k], 1'b0);
            checkOutput("reset cs_n", csN[k], 1'b1);
            checkOutput("reset sck", sck[k], 1'b0);
            checkOutput("reset mosi", mosi[k], 1'b0);
            checkOutput("reset ldac_n", ldacN[k], 1'b1);
        end
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] single frame 0xA5C");
        applyStimulus(0, 12'hA5C, 16'h3A5C, 1'b0, t0);
        waitDone(0);

        $display("[TB] valid held high, 0x000 then 0xFFF");
        ovBase = ovCount[0];
        applyStimulus(0, 12'h000, 16'h3000, 1'b1, ta);
        applyStimulus(0, 12'hFFF, 16'h3FFF, 1'b0, tb);
        waitDone(0);
        checkOutput("back-to-back spacing", tb - ta, 137);
        checkOutput("overrun pulse count", ovCount[0] - ovBase, 136);

        $display("[TB] reset mid-frame");
        ldBase = ldacFalls[0];
        applyStimulus(0, 12'h5A5, 16'h35A5, 1'b0, t0);
        n = 0;
        while (cyc != t0 + 50 && n < 200) begin
            @(negedge clk);
            n++;
        end
        reset = 1'b1;
        #1;
        checkOutput("abort cs_n", csN[0], 1'b1);
        checkOutput("abort sck", sck[0], 1'b0);
        checkOutput("abort ldac_n", ldacN[0], 1'b1);
        checkOutput("abort ready", rdy[0], 1'b1);
        sb.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (150) @(negedge clk);
        checkOutput("no ldac after abort", ldacFalls[0] - ldBase, 0);
        checkOutput("ready after abort", rdy[0], 1'b1);
        applyStimulus(0, 12'hF0F, 16'h3F0F, 1'b0, t0);
        waitDone(0);

        $display("[TB] CLK_DIV=1 BUF=1 GA_N=0 sample 0x001");
        applyStimulus(1, 12'h001, 16'h5001, 1'b0, t0);
        waitDone(1);

        $display("[TB] sample changed mid-frame");
        ovBase = ovCount[0];
        applyStimulus(0, 12'hABC, 16'h3ABC, 1'b0, t0);
        n = 0;
        while (cyc != t0 + 10 && n < 50) begin
            @(negedge clk);
            n++;
        end
        samp0 = 12'h123;
        waitDone(0);
        checkOutput("no overrun mid-frame change", ovCount[0] - ovBase, 0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
